// File: rtl/network_mac_pipe.sv
// Pipelined signed multiply-accumulate with first/last dot-product framing, rounding and rescale.
// Define NETWORK_MAC_SAT_EN to saturate the rescaled result (and flag overflow) instead of wrapping.
module network_mac_pipe #(
  parameter int unsigned A_WIDTH     = 16,
  parameter int unsigned B_WIDTH     = 14,
  parameter int unsigned PIPE_STAGES = 3,
  parameter int unsigned ACC_WIDTH   = 40,
  parameter int unsigned FRAC_SHIFT  = 13,
  parameter int unsigned OUT_WIDTH   = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ce,
  input  logic                        in_valid,
  input  logic                        in_first,
  input  logic                        in_last,
  input  logic signed [A_WIDTH-1:0]   din0,
  input  logic signed [B_WIDTH-1:0]   din1,
  output logic                        out_valid,
  output logic signed [OUT_WIDTH-1:0] dout,
  output logic                        overflow
);

  localparam int unsigned PW = A_WIDTH + B_WIDTH;
  localparam int unsigned PS = PIPE_STAGES - 1;
  localparam int unsigned RW = ACC_WIDTH + 1;
  localparam logic signed [RW-1:0] RND = RW'((64'(1) << FRAC_SHIFT) >> 1);

  logic signed [A_WIDTH-1:0]   a_q;
  logic signed [B_WIDTH-1:0]   b_q;
  logic                        v_q, f_q, l_q;
  logic signed [PW-1:0]        p_q [PS];
  logic [PS-1:0]               pv_q, pf_q, pl_q;
  logic signed [ACC_WIDTH-1:0] acc_q;

  logic signed [PW-1:0]        prod_c;
  logic signed [ACC_WIDTH-1:0] acc_base_c, acc_next_c;
  logic signed [RW-1:0]        r_c;
  logic signed [OUT_WIDTH-1:0] dout_c;
  logic                        ovf_c;

  // Accumulate and round-half-up rescale; one spare bit keeps the rounding add from wrapping.
  always_comb begin
    prod_c     = PW'(a_q) * PW'(b_q);
    acc_base_c = pf_q[PS-1] ? '0 : acc_q;
    acc_next_c = acc_base_c + ACC_WIDTH'(p_q[PS-1]);
    r_c        = (RW'(acc_next_c) + RND) >>> FRAC_SHIFT;
  end

`ifdef NETWORK_MAC_SAT_EN
  localparam logic signed [RW-1:0] OMAX = RW'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [RW-1:0] OMIN = ~OMAX;

  always_comb begin
    dout_c = OUT_WIDTH'(r_c);
    ovf_c  = 1'b0;
    if (r_c > OMAX) begin
      dout_c = OUT_WIDTH'(OMAX);
      ovf_c  = 1'b1;
    end else if (r_c < OMIN) begin
      dout_c = OUT_WIDTH'(OMIN);
      ovf_c  = 1'b1;
    end
  end
`else
  assign dout_c = OUT_WIDTH'(r_c);
  assign ovf_c  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q       <= '0;
      b_q       <= '0;
      v_q       <= 1'b0;
      f_q       <= 1'b0;
      l_q       <= 1'b0;
      p_q       <= '{default: '0};
      pv_q      <= '0;
      pf_q      <= '0;
      pl_q      <= '0;
      acc_q     <= '0;
      out_valid <= 1'b0;
      dout      <= '0;
      overflow  <= 1'b0;
    end else if (ce) begin
      a_q     <= din0;
      b_q     <= din1;
      v_q     <= in_valid;
      f_q     <= in_first;
      l_q     <= in_last;
      p_q[0]  <= prod_c;
      pv_q[0] <= v_q;
      pf_q[0] <= f_q;
      pl_q[0] <= l_q;
      // Product delay line; flags travel with their term.
      for (int unsigned i = 1; i < PS; i++) begin
        p_q[i]  <= p_q[i-1];
        pv_q[i] <= pv_q[i-1];
        pf_q[i] <= pf_q[i-1];
        pl_q[i] <= pl_q[i-1];
      end
      if (pv_q[PS-1]) begin
        acc_q <= acc_next_c;
      end
      out_valid <= pv_q[PS-1] & pl_q[PS-1];
      if (pv_q[PS-1] && pl_q[PS-1]) begin
        dout     <= dout_c;
        overflow <= ovf_c;
      end
    end
  end

endmodule

// File: tb/tb_network_mac_pipe.sv
// Directed plus random bench for network_mac_pipe against a per-term arithmetic model.
module tb_network_mac_pipe;

  localparam int AW = 16, BW = 14, PS = 3, ACCW = 40, FS = 13, OW = 16;

  logic clk = 1'b0;
  logic reset, ce, in_valid, in_first, in_last;
  logic signed [AW-1:0] din0;
  logic signed [BW-1:0] din1;
  logic out_valid;
  logic signed [OW-1:0] dout;
  logic overflow;

  network_mac_pipe #(
    .A_WIDTH(AW), .B_WIDTH(BW), .PIPE_STAGES(PS),
    .ACC_WIDTH(ACCW), .FRAC_SHIFT(FS), .OUT_WIDTH(OW)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
    .in_first(in_first), .in_last(in_last), .din0(din0), .din1(din1),
    .out_valid(out_valid), .dout(dout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                   due;
    logic signed [OW-1:0] d;
    logic                 o;
  } res_t;

  int errors = 0;
  int checks = 0;

  res_t                 pending[$];
  longint               macc = 0;
  int                   edges = 0;
  logic                 exp_valid = 1'b0;
  logic signed [OW-1:0] exp_dout = '0;
  logic                 exp_ovf = 1'b0;

  // Result of a finished dot product, from the rounding/rescale rules.
  task automatic finish_sum(input longint acc, output logic signed [OW-1:0] d, output logic o);
    longint r, lo, hi;
    logic [63:0] rb;
    r  = (acc + (longint'(1) <<< (FS - 1))) >>> FS;
    lo = -(longint'(1) <<< (OW - 1));
    hi = (longint'(1) <<< (OW - 1)) - 1;
    rb = r;
`ifdef NETWORK_MAC_SAT_EN
    if (r > hi) begin d = OW'(hi); o = 1'b1; end
    else if (r < lo) begin d = OW'(lo); o = 1'b1; end
    else begin d = rb[OW-1:0]; o = 1'b0; end
`else
    d = rb[OW-1:0];
    o = 1'b0;
`endif
  endtask

  task automatic step(input logic rst, input logic c, input logic v, input logic f, input logic l,
                      input int a, input int b, input string tag);
    res_t e;
    reset    = rst;
    ce       = c;
    in_valid = v;
    in_first = f;
    in_last  = l;
    din0     = AW'(a);
    din1     = BW'(b);
    @(posedge clk);
    #1;
    if (rst) begin
      pending.delete();
      macc      = 0;
      edges     = 0;
      exp_valid = 1'b0;
      exp_dout  = '0;
      exp_ovf   = 1'b0;
    end else if (c) begin
      edges++;
      if (v) begin
        longint p;
        p    = longint'(din0) * longint'(din1);
        macc = f ? p : macc + p;
        macc = (macc <<< (64 - ACCW)) >>> (64 - ACCW);
        if (l) begin
          e.due = edges + PS;
          finish_sum(macc, e.d, e.o);
          pending.push_back(e);
        end
      end
      exp_valid = 1'b0;
      if (pending.size() > 0 && pending[0].due == edges) begin
        e         = pending.pop_front();
        exp_valid = 1'b1;
        exp_dout  = e.d;
        exp_ovf   = e.o;
      end
    end
    checks++;
    assert (out_valid === exp_valid) else begin
      errors++;
      $error("FAIL %s out_valid got=%b exp=%b", tag, out_valid, exp_valid);
    end
    checks++;
    assert (dout === exp_dout) else begin
      errors++;
      $error("FAIL %s dout got=%0d exp=%0d", tag, dout, exp_dout);
    end
    checks++;
    assert (overflow === exp_ovf) else begin
      errors++;
      $error("FAIL %s overflow got=%b exp=%b", tag, overflow, exp_ovf);
    end
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, tag);
  endtask

  initial begin
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, "reset0");
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5, 5, "reset1");

    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 100, 4096, "single");
    idle(5, "single_out");

    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 100, 4096, "dot3_t0");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 200, 4096, "dot3_t1");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, -50, 4096, "dot3_t2");
    idle(5, "dot3_out");

    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3, 4096, "round_pos");
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, -3, 4096, "round_neg");
    idle(5, "round_out");

    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32767, 8191, "big_t0");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32767, 8191, "big_t1");
    idle(5, "big_out");

    // ce stalls and bubbles inside a dot product, then stalls while the result is up
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 100, 4096, "ce_t0");
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 999, 999, "ce_off0");
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 999, 999, "ce_off1");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, "ce_bub0");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 200, 4096, "ce_t1");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 7, 7, "ce_bub1");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, -50, 4096, "ce_t2");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, "ce_w0");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, "ce_w1");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, "ce_w2");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, "ce_hold0");
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 9, 9, "ce_hold1");
    idle(3, "ce_drain");

    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 100, 4096, "rst_t0");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 200, 4096, "rst_t1");
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, "rst_mid");
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 7, 4096, "rst_fresh");
    idle(6, "rst_out");

    // first without last mid-sum, last without first, then random traffic
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1000, 2000, "reopen_t0");
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 300, -4096, "reopen_t1");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 10, 4096, "reopen_t2");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 20, 4096, "cont_last");
    idle(5, "reopen_out");

    for (int i = 0; i < 400; i++) begin
      logic r, c, v, f, l;
      r = ($urandom_range(0, 59) == 0);
      c = ($urandom_range(0, 4) != 0);
      v = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 3) == 0);
      l = ($urandom_range(0, 2) == 0);
      step(r, c, v, f, l, int'($urandom), int'($urandom), "random");
    end
    idle(6, "final_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
